cop_dispatch_ctrl: RTL
======================

# cop_dispatch_ctrl

Multicycle dispatch controller for the coprocessor path of the single-cycle RISC-V core. It decodes custom-0 instructions, selects one of `NUM_UNITS` coprocessor units (GCD, LCM, …) by `funct3`, and handles the operand/start handshake. It stalls the core until the selected unit signals done or a timeout expires, then presents one write-back beat. It generalises the one-shot start decode into a parametrised, handshaked, multi-unit FSM with a timeout and illegal-select detection.

## Interface
Parameters:
- `XLEN`, 32, operand/result width
- `NUM_UNITS`, 2, number of attached units (1..8); unit index = `funct3`
- `TIMEOUT_CYCLES`, 1024, max WAIT cycles before abort; 0 disables the timeout
- `ERR_RESULT`, all-ones, `wb_data` value on timeout

Ports:
- `clk`  in  1  the single clock
- `reset`  in  1  synchronous, active-high reset
- `instr_valid`  in  1  the current instruction is valid
- `op`  in  7  opcode field
- `funct3`  in  3  unit select
- `rs1_val`, `rs2_val`  in  XLEN  source operands
- `cop_start`  out  NUM_UNITS  one-hot start pulse
- `cop_a`, `cop_b`  out  XLEN  latched operands, stable from ISSUE through WAIT
- `cop_done`  in  NUM_UNITS  per-unit done pulse
- `cop_result`  in  NUM_UNITS×XLEN  per-unit result, valid with done
- `stall`  out  1  holds the PC and register file
- `wb_valid`  out  1  one-cycle write-back strobe
- `wb_data`  out  XLEN  write-back value
- `err`  out  1  with `wb_valid`: the operation timed out
- `illegal`  out  1  one-cycle pulse: `funct3` ≥ `NUM_UNITS`

## Operation
- **Request:** `req = instr_valid & op==CUSTOM0 (7'b0001011)`.
- **FSM states:** IDLE, ISSUE, WAIT, WB.
- **IDLE → ISSUE:**
  - Taken on `req` with a legal `funct3`.
  - Latches `rs1_val`/`rs2_val` into `cop_a`/`cop_b` and `funct3` into `sel`.
  - Clears the timeout counter.
- **IDLE, illegal select:** On `req` with `funct3` ≥ `NUM_UNITS`, pulse `illegal` for 1 cycle, do not assert `stall`, stay in IDLE.
- **ISSUE → WAIT:** `cop_start[sel]=1` for exactly this cycle.
- **WAIT:**
  - `cop_done[sel]` → capture `cop_result[sel]` into `wb_data`, set `err=0`, go to WB.
  - Counter reaches `TIMEOUT_CYCLES` (when nonzero) → `wb_data=ERR_RESULT`, `err=1`, go to WB.
  - If done and timeout occur in the same cycle, done wins.
  - Otherwise increment the counter.
- **WB → IDLE:** `wb_valid=1` for 1 cycle and `stall=0`, so the core retires the instruction at this edge. `req` is ignored in WB because the same instruction is still presented.
- **Stall:** `stall = (IDLE & req & legal) | ISSUE | WAIT`. In IDLE this term is combinational and is asserted in the decode cycle.
- **Ignored inputs:**
  - `cop_done` bits of unselected units are ignored in every state.
  - `cop_done[sel]` is ignored outside WAIT.
- **Width rules:** The counter is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates rather than wrapping. `wb_data` and `err` hold their values after WB until the next capture.

## Timing
- **Reset values:** state IDLE; `cop_start=0`, `wb_valid=0`, `wb_data=0`, `err=0`, `illegal=0`, `cop_a=0`, `cop_b=0`, counter 0.
- **Stall with idle inputs:** `stall=0` when `instr_valid=0`.
- **Minimum latency:** Decode (cycle 0), ISSUE (cycle 1), done in the first WAIT cycle (cycle 2), WB (cycle 3). The core stalls for 3 cycles.
- **Latency with unit delay:** If a unit takes D WAIT cycles to assert done, total latency is 2+D+1 cycles.
- **Timeout:** WB is reached after `TIMEOUT_CYCLES` WAIT cycles.
- **Reset mid-operation:** Returns to IDLE next edge, drops `cop_start` and `stall`, and produces no `wb_valid`. Units must be reset by the same `reset`.
- **Back-to-back:** A new custom instruction can be accepted in the cycle after WB.
- **Registered outputs:** All outputs except `stall` are registered.

## Structure
- **Package `cop_pkg`:**
  - `cop_state_t` enum (IDLE, ISSUE, WAIT, WB)
  - `OP_CUSTOM0` constant
  - `UNIT_GCD=0` and `UNIT_LCM=1` index constants
  - default `TIMEOUT_CYCLES`
- **Sub-module `cop_timeout_ctr`:** saturating counter with `clear`/`en` inputs and a `hit` output. It is instantiated once and is omitted under generate when `TIMEOUT_CYCLES==0`.
- **Integration:** The core controller consumes `stall`. `wb_valid` gates `RegWrite` and `wb_data` feeds the result mux.

## Test plan
- **Nominal GCD:** `op=0001011`, `funct3=0`, rs1=48, rs2=18; unit 0 asserts done 5 WAIT cycles later with result 6. Expect `cop_start=2'b01` for 1 cycle, `stall` high for 7 cycles, then `wb_valid=1`, `wb_data=6`, `err=0`.
- **LCM select:** `funct3=1`, rs1=4, rs2=6; done with result 12, while unit 0 pulses done spuriously mid-WAIT. Expect the spurious done ignored and `wb_data=12`.
- **Illegal select:** `funct3=5` with `NUM_UNITS=2`. Expect `illegal` for 1 cycle, `stall=0`, no `cop_start`, state stays IDLE.
- **Timeout:** `TIMEOUT_CYCLES=8`, never assert done. Expect WB after 8 WAIT cycles, `wb_data=32'hFFFF_FFFF`, `err=1`. A second run asserts done and the timeout in the same cycle; expect `err=0`.
- **Reset mid-WAIT:** assert `reset` for 1 cycle. Expect state IDLE, `stall=0`, no `wb_valid`; a subsequent operation completes normally.
- **Back-to-back:** two custom instructions in consecutive instruction slots. Expect the second `cop_start` exactly 2 cycles after the first `wb_valid`, and no double issue during WB.

Source files
------------

// File: rtl/cop_dispatch_ctrl_pkg.sv
// Shared types and constants for the coprocessor dispatch controller.
package cop_pkg;

   // Controller FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WB    = 2'd3
   } cop_state_t;

   // RISC-V custom-0 major opcode
   localparam logic [6:0] OP_CUSTOM0 = 7'b0001011;

   // Unit indices, selected by funct3
   localparam int UNIT_GCD = 0;
   localparam int UNIT_LCM = 1;

   // Default number of WAIT cycles before an operation is aborted
   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/cop_dispatch_ctrl_if.sv
// Bundle of the core-side and unit-side signals of the dispatch controller.
//
// Handshake semantics:
//   - Core side: a request is instr_valid & op==custom-0. While stall is high
//     the core holds the same instruction, PC and register file. The
//     instruction retires on the single cycle wb_valid is high (stall low
//     then); wb_data/err are valid in that cycle.
//   - Unit side: cop_start[u] is a one-cycle pulse with cop_a/cop_b valid and
//     held until the result is taken. The unit answers with a one-cycle
//     cop_done[u], with cop_result slice u valid in that same cycle.
interface cop_dispatch_ctrl_if #(
   parameter int XLEN      = 32,
   parameter int NUM_UNITS = 2
);

   logic                      instr_valid;
   logic [6:0]                op;
   logic [2:0]                funct3;
   logic [XLEN-1:0]           rs1_val;
   logic [XLEN-1:0]           rs2_val;
   logic [NUM_UNITS-1:0]      cop_start;
   logic [XLEN-1:0]           cop_a;
   logic [XLEN-1:0]           cop_b;
   logic [NUM_UNITS-1:0]      cop_done;
   logic [NUM_UNITS*XLEN-1:0] cop_result;
   logic                      stall;
   logic                      wb_valid;
   logic [XLEN-1:0]           wb_data;
   logic                      err;
   logic                      illegal;

   // Core and coprocessor units drive the requests and results
   modport master (
      output instr_valid, op, funct3, rs1_val, rs2_val, cop_done, cop_result,
      input  cop_start, cop_a, cop_b, stall, wb_valid, wb_data, err, illegal
   );

   // The dispatch controller
   modport slave (
      input  instr_valid, op, funct3, rs1_val, rs2_val, cop_done, cop_result,
      output cop_start, cop_a, cop_b, stall, wb_valid, wb_data, err, illegal
   );

endinterface

// File: rtl/cop_dispatch_ctrl_timeout_ctr.sv
// Saturating WAIT-cycle counter. o_hit is high in the cycle whose count
// completes MAX_CYCLES enabled cycles since the last clear.
module cop_timeout_ctr #(
   parameter int MAX_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_en,
   output logic o_hit
);

   localparam int             W       = $clog2(MAX_CYCLES + 1);
   localparam logic [W-1:0]   LP_MAX  = W'(MAX_CYCLES);
   localparam logic [W-1:0]   LP_LAST = W'(MAX_CYCLES - 1);

   logic [W-1:0] r_cnt;

   // Count enabled cycles, stop at MAX_CYCLES instead of wrapping
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != LP_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // The current cycle is the MAX_CYCLES-th enabled one
   assign o_hit = (r_cnt >= LP_LAST);

endmodule

// File: rtl/cop_dispatch_ctrl.sv
// Dispatch controller for custom-0 coprocessor instructions: decodes the
// request, starts the unit chosen by funct3, stalls the core until done or
// timeout, then presents one write-back beat.
module cop_dispatch_ctrl
   import cop_pkg::*;
#(
   parameter int              XLEN           = 32,
   parameter int              NUM_UNITS      = 2,
   parameter int              TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter logic [XLEN-1:0] ERR_RESULT     = '1
) (
   input  logic                clk,
   input  logic                reset,
   cop_dispatch_ctrl_if.slave  bus,
   output cop_state_t          o_state
);

   cop_state_t           r_state;
   cop_state_t           w_state_nxt;

   logic [XLEN-1:0]      r_cop_a;
   logic [XLEN-1:0]      r_cop_b;
   logic [2:0]           r_sel;
   logic [NUM_UNITS-1:0] r_cop_start;
   logic                 r_wb_valid;
   logic [XLEN-1:0]      r_wb_data;
   logic                 r_err;
   logic                 r_illegal;

   logic                 w_req;
   logic                 w_legal;
   logic                 w_sel_done;
   logic [XLEN-1:0]      w_sel_result;
   logic                 w_to_hit;
   logic                 w_to_en;
   logic                 w_accept;
   logic                 w_capture;
   logic                 w_stall;
   logic [NUM_UNITS-1:0] w_start_nxt;
   logic                 w_wb_valid_nxt;
   logic                 w_illegal_nxt;
   logic [XLEN-1:0]      w_wb_data_nxt;
   logic                 w_err_nxt;

   assign w_req   = bus.instr_valid && (bus.op == OP_CUSTOM0);
   assign w_legal = (int'(bus.funct3) < NUM_UNITS);

   // Pick done/result of the latched unit; other units' done bits are ignored
   always_comb begin
      w_sel_done   = 1'b0;
      w_sel_result = '0;
      for (int u = 0; u < NUM_UNITS; u++) begin
         if (r_sel == 3'(u)) begin
            w_sel_done   = bus.cop_done[u];
            w_sel_result = bus.cop_result[u*XLEN +: XLEN];
         end
      end
   end

   // Optional WAIT timeout; absent entirely when TIMEOUT_CYCLES is zero
   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         cop_timeout_ctr #(
            .MAX_CYCLES (TIMEOUT_CYCLES)
         ) u_timeout (
            .clk     (clk),
            .reset   (reset),
            .i_clear (w_accept),
            .i_en    (w_to_en),
            .o_hit   (w_to_hit)
         );
      end else begin : g_no_timeout
         assign w_to_hit = 1'b0;
      end
   endgenerate

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; WB always returns to IDLE so the held request is ignored
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_req && w_legal) w_state_nxt = ST_ISSUE;
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT:  if (w_sel_done || w_to_hit) w_state_nxt = ST_WB;
         ST_WB:    w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: combinational stall plus next values of registered outputs
   always_comb begin
      w_stall        = 1'b0;
      w_accept       = 1'b0;
      w_capture      = 1'b0;
      w_to_en        = 1'b0;
      w_start_nxt    = '0;
      w_wb_valid_nxt = 1'b0;
      w_illegal_nxt  = 1'b0;
      w_wb_data_nxt  = '0;
      w_err_nxt      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               if (w_legal) begin
                  w_stall  = 1'b1;
                  w_accept = 1'b1;
                  for (int u = 0; u < NUM_UNITS; u++) begin
                     w_start_nxt[u] = (bus.funct3 == 3'(u));
                  end
               end else begin
                  w_illegal_nxt = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            w_stall = 1'b1;
         end
         ST_WAIT: begin
            w_stall = 1'b1;
            // A done arriving in the timeout cycle still delivers its result
            if (w_sel_done) begin
               w_capture      = 1'b1;
               w_wb_data_nxt  = w_sel_result;
               w_err_nxt      = 1'b0;
               w_wb_valid_nxt = 1'b1;
            end else if (w_to_hit) begin
               w_capture      = 1'b1;
               w_wb_data_nxt  = ERR_RESULT;
               w_err_nxt      = 1'b1;
               w_wb_valid_nxt = 1'b1;
            end else begin
               w_to_en = 1'b1;
            end
         end
         default: begin
            w_stall = 1'b0;
         end
      endcase
   end

   // Registered outputs and operand/select latches
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cop_a     <= '0;
         r_cop_b     <= '0;
         r_sel       <= '0;
         r_cop_start <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_data   <= '0;
         r_err       <= 1'b0;
         r_illegal   <= 1'b0;
      end else begin
         r_cop_start <= w_start_nxt;
         r_wb_valid  <= w_wb_valid_nxt;
         r_illegal   <= w_illegal_nxt;
         if (w_accept) begin
            r_cop_a <= bus.rs1_val;
            r_cop_b <= bus.rs2_val;
            r_sel   <= bus.funct3;
         end
         if (w_capture) begin
            r_wb_data <= w_wb_data_nxt;
            r_err     <= w_err_nxt;
         end
      end
   end

   assign bus.cop_start = r_cop_start;
   assign bus.cop_a     = r_cop_a;
   assign bus.cop_b     = r_cop_b;
   assign bus.stall     = w_stall;
   assign bus.wb_valid  = r_wb_valid;
   assign bus.wb_data   = r_wb_data;
   assign bus.err       = r_err;
   assign bus.illegal   = r_illegal;
   assign o_state       = r_state;

endmodule
